seq_mult_scheduler: RTL and testbench
=====================================

SEQ_MULT_SCHEDULER -- requirements
Module: seq_mult_scheduler

Interface
REQ-001 The block SHALL have a single clock, C, and a reset, R, which is asynchronous and active-high.
REQ-002 C  in  1  clock; all state changes on the rising edge.
REQ-003 R  in  1  reset; asynchronous, active-high.
REQ-004 REQ0, REQ1  in  1 each  multiply request from requester 0 / 1; level, held until matching GNT.
REQ-005 M0, Q0  in  4 each  multiplicand / multiplier from requester 0, unsigned.
REQ-006 M1, Q1  in  4 each  multiplicand / multiplier from requester 1, unsigned.
REQ-007 GNT0, GNT1  out  1 each  one-cycle grant pulse; operands of that requester were captured.
REQ-008 BUSY  out  1  high while a multiply is in progress (state CALC).
REQ-009 DONE  out  1  one-cycle pulse; Z and ID are valid.
REQ-010 ID  out  1  requester whose product is on Z.
REQ-011 Z  out  8  unsigned product, held until the next DONE.

Function
REQ-012 The block SHALL implement states IDLE, CALC and FIN.
REQ-013 Arbitration SHALL be evaluated at a rising edge in IDLE or FIN; the block samples REQ0/REQ1 at that edge.
REQ-014 Single request: that requester SHALL win.
REQ-015 Both requesting: the requester named by priority pointer PRI SHALL win.
REQ-016 After every grant, PRI SHALL point to the non-granted requester.
REQ-017 No request in IDLE: stay in IDLE. No request in FIN: go to IDLE.
REQ-018 On the grant edge, the block SHALL latch the winner's M into Mreg and its Q into Qreg, clear the 4-bit accumulator A and carry Cy, clear the 2-bit counter CNT, record the winner in an internal tag, and enter CALC.
REQ-019 The GNTx of the winner SHALL be high for exactly the first CALC cycle; the other GNT SHALL stay low.
REQ-020 Each CALC edge SHALL perform one shift-add step.
  - If Qreg[0]=1, {Cy,A} = A + Mreg (5-bit sum); otherwise {Cy,A} = {0,A}.
  - Shift {Cy,A,Qreg} right by one, with 0 into Cy.
  - Increment CNT.
REQ-021 On the 4th CALC edge (CNT=3), the block SHALL compute the final step, load Z = {A,Qreg} (8 bits) and ID = tag, and enter FIN.
REQ-022 DONE SHALL be high for exactly the FIN cycle: 5 cycles after the grant edge (GNT cycle plus 3 more CALC cycles, then FIN).
REQ-023 Throughput: a request sampled on the FIN edge SHALL start immediately, giving one product per 5 cycles under continuous load.
REQ-024 REQx changes and M/Q changes during CALC SHALL be ignored; operands are taken only on the grant edge.
REQ-025 BUSY SHALL equal (state==CALC).
REQ-026 Z SHALL be an exact 4x4 unsigned product (max 15*15=225); no overflow is possible.
REQ-027 Z and ID SHALL change only on the edge entering FIN.

Reset
REQ-028 R high SHALL immediately force the following, regardless of C: state IDLE; PRI=0; GNT0=GNT1=BUSY=DONE=ID=0; Z=0; A, Cy, Qreg, Mreg, CNT cleared.
REQ-029 Reset during CALC SHALL discard the in-flight operation: no DONE and no Z update.
REQ-030 After R deasserts, the first arbitration SHALL be at the first rising edge with R low.

Verification
REQ-031 Basic: reset, then REQ0=1, M0=4'b1101, Q0=4'b1101 -> GNT0 pulse next cycle; DONE 5 cycles after the grant edge; Z=8'hA9 (169); ID=0.
REQ-032 Contention: REQ0=REQ1=1, M0=3, Q0=5, M1=15, Q1=15, both held.
  - First grant GNT0 -> Z=15, ID=0.
  - Second grant GNT1, taken on the FIN edge -> Z=225, ID=1.
  - Third grant returns to requester 0.
REQ-033 Zero/ones: M1=0, Q1=15 -> Z=0. Then M1=15, Q1=1 -> Z=15. DONE once per operation.
REQ-034 Operand change mid-op: after GNT0, change M0/Q0 every cycle -> Z equals the product of the values present at the grant edge.
REQ-035 Reset mid-op: assert R for one cycle during the 2nd CALC cycle -> all outputs 0 immediately, no DONE. A subsequent request with 7*9 gives Z=63.
REQ-036 Idle hold: after a DONE, with no requests for 10 cycles -> Z and ID are stable; BUSY, DONE and GNT stay low.

Source files
------------

// File: rtl/seq_mult_scheduler_if.sv
// Request/grant and result bus between two multiply requesters and the shared
// sequential multiplier.
interface seq_mult_scheduler_if;
    logic       req0;
    logic       req1;
    logic [3:0] m0;
    logic [3:0] q0;
    logic [3:0] m1;
    logic [3:0] q1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic       id;
    logic [7:0] z;

    modport master (
        output req0, req1, m0, q0, m1, q1,
        input  gnt0, gnt1, busy, done, id, z
    );

    modport slave (
        input  req0, req1, m0, q0, m1, q1,
        output gnt0, gnt1, busy, done, id, z
    );
endinterface

// File: rtl/seq_mult_scheduler.sv
// Two-requester arbiter in front of a 4x4 unsigned shift-add multiplier.
// One product every 5 cycles under continuous load.
module seq_mult_scheduler (
    input  logic                 clk,
    input  logic                 rst,
    seq_mult_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t     state;
    state_t     state_next;
    logic       pri;
    logic       tag;
    logic       cy;
    logic [3:0] mreg;
    logic [3:0] qreg;
    logic [3:0] a;
    logic [1:0] cnt;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       done_r;
    logic       id_r;
    logic [7:0] z_r;

    logic       arb_ok;
    logic       winner;
    logic [4:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Arbitration happens in IDLE and FIN, so a request seen on the FIN edge
    // starts back-to-back with the previous product.
    always_comb begin
        state_next = state;
        arb_ok     = 1'b0;
        winner     = 1'b0;
        sum        = {cy, a};
        if (qreg[0]) sum = {1'b0, a} + {1'b0, mreg};
        winner = (bus.req0 && bus.req1) ? pri : bus.req1;
        case (state)
            IDLE, FIN: begin
                arb_ok     = bus.req0 || bus.req1;
                state_next = arb_ok ? CALC : IDLE;
            end
            CALC: begin
                if (cnt == 2'd3) state_next = FIN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift step: {cy,a,qreg} <= {0, sum, qreg} >> 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri    <= 1'b0;
            tag    <= 1'b0;
            cy     <= 1'b0;
            mreg   <= '0;
            qreg   <= '0;
            a      <= '0;
            cnt    <= '0;
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            done_r <= 1'b0;
            id_r   <= 1'b0;
            z_r    <= '0;
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            done_r <= 1'b0;
            if (arb_ok) begin
                mreg   <= winner ? bus.m1 : bus.m0;
                qreg   <= winner ? bus.q1 : bus.q0;
                a      <= '0;
                cy     <= 1'b0;
                cnt    <= '0;
                tag    <= winner;
                pri    <= ~winner;
                gnt0_r <= ~winner;
                gnt1_r <= winner;
            end else if (state == CALC) begin
                a    <= sum[4:1];
                qreg <= {sum[0], qreg[3:1]};
                cy   <= 1'b0;
                cnt  <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    z_r    <= {sum[4:1], sum[0], qreg[3:1]};
                    id_r   <= tag;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt0 = gnt0_r;
    assign bus.gnt1 = gnt1_r;
    assign bus.busy = (state == CALC);
    assign bus.done = done_r;
    assign bus.id   = id_r;
    assign bus.z    = z_r;
endmodule

// File: tb/tb_seq_mult_scheduler.sv
// Directed bench for seq_mult_scheduler: basic, contention, edge operands,
// idle hold, operand change mid-op and reset mid-op.
module tb_seq_mult_scheduler;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    seq_mult_scheduler_if bus ();

    seq_mult_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " gnt0"}, {7'd0, bus.gnt0}, 8'd0);
        check_output({tag, " gnt1"}, {7'd0, bus.gnt1}, 8'd0);
        check_output({tag, " busy"}, {7'd0, bus.busy}, 8'd0);
        check_output({tag, " done"}, {7'd0, bus.done}, 8'd0);
        check_output({tag, " id"},   {7'd0, bus.id},   8'd0);
        check_output({tag, " z"},    bus.z,            8'd0);
    endtask

    // Called with the request already set before the grant edge; returns at
    // the negedge of the FIN cycle.
    task automatic run_op(input string tag, input bit exp_id, input logic [7:0] exp_z,
                          input bit drop, input bit scramble);
        @(negedge clk);
        check_output({tag, " gnt0"}, {7'd0, bus.gnt0}, {7'd0, ~exp_id});
        check_output({tag, " gnt1"}, {7'd0, bus.gnt1}, {7'd0, exp_id});
        check_output({tag, " busy"}, {7'd0, bus.busy}, 8'd1);
        check_output({tag, " done@gnt"}, {7'd0, bus.done}, 8'd0);
        if (drop) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (scramble) begin
                bus.m0 = 4'($urandom);
                bus.q0 = 4'($urandom);
            end
            @(negedge clk);
            check_output({tag, " done early"}, {7'd0, bus.done}, 8'd0);
            check_output({tag, " busy calc"},  {7'd0, bus.busy}, 8'd1);
            check_output({tag, " gnt calc"},   {7'd0, bus.gnt0 | bus.gnt1}, 8'd0);
        end
        @(negedge clk);
        check_output({tag, " done"},     {7'd0, bus.done}, 8'd1);
        check_output({tag, " busy fin"}, {7'd0, bus.busy}, 8'd0);
        check_output({tag, " z"},        bus.z, exp_z);
        check_output({tag, " id"},       {7'd0, bus.id}, {7'd0, exp_id});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.m0     = '0;
        bus.q0     = '0;
        bus.m1     = '0;
        bus.q1     = '0;

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle after reset");

        // 13*13 = 169
        bus.req0 = 1'b1;
        bus.m0   = 4'd13;
        bus.q0   = 4'd13;
        run_op("basic", 1'b0, 8'd169, 1'b1, 1'b0);

        rst = 1'b1;
        #1;
        check_all_zero("reset after basic");
        @(negedge clk);
        rst = 1'b0;

        // Both held: 0, 1, 0
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.m0   = 4'd3;
        bus.q0   = 4'd5;
        bus.m1   = 4'd15;
        bus.q1   = 4'd15;
        run_op("contend1", 1'b0, 8'd15,  1'b0, 1'b0);
        run_op("contend2", 1'b1, 8'd225, 1'b0, 1'b0);
        run_op("contend3", 1'b0, 8'd15,  1'b1, 1'b0);

        bus.req1 = 1'b1;
        bus.m1   = 4'd0;
        bus.q1   = 4'd15;
        run_op("zero", 1'b1, 8'd0, 1'b1, 1'b0);
        bus.req1 = 1'b1;
        bus.m1   = 4'd15;
        bus.q1   = 4'd1;
        run_op("ones", 1'b1, 8'd15, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("hold z",    bus.z, 8'd15);
            check_output("hold id",   {7'd0, bus.id}, 8'd1);
            check_output("hold busy", {7'd0, bus.busy}, 8'd0);
            check_output("hold done", {7'd0, bus.done}, 8'd0);
            check_output("hold gnt",  {7'd0, bus.gnt0 | bus.gnt1}, 8'd0);
        end

        // 6*11 = 66 while operands are scrambled after the grant
        bus.req0 = 1'b1;
        bus.m0   = 4'd6;
        bus.q0   = 4'd11;
        run_op("opchange", 1'b0, 8'd66, 1'b1, 1'b1);

        bus.req0 = 1'b1;
        bus.m0   = 4'd2;
        bus.q0   = 4'd3;
        @(negedge clk);
        check_output("abort gnt0", {7'd0, bus.gnt0}, 8'd1);
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("abort reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("abort no done", {7'd0, bus.done}, 8'd0);
            check_output("abort z",       bus.z, 8'd0);
            check_output("abort busy",    {7'd0, bus.busy}, 8'd0);
        end

        bus.req0 = 1'b1;
        bus.m0   = 4'd7;
        bus.q0   = 4'd9;
        run_op("post reset", 1'b0, 8'd63, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
